// File: rtl/rom_burst_reader_if.sv
// Handshake bundle for rom_burst_reader: burst command, abort, and the
// valid/ready stream of ROM words. When ROM_PARITY_EN is defined the bundle
// also carries parity_o alongside the data.
interface rom_burst_reader_if #(
    parameter int W  = 32,
    parameter int AW = 8
);
    logic          start_i;
    logic [AW-1:0] addr_i;
    logic [AW-1:0] len_i;
    logic          abort_i;
    logic          ready_i;
    logic [W-1:0]  data_o;
    logic          valid_o;
    logic [AW-1:0] addr_o;
    logic          last_o;
    logic          oor_o;
    logic          busy_o;
    logic          done_o;
`ifdef ROM_PARITY_EN
    logic          parity_o;
`endif

    // Consumer / command side
    modport master (
        output start_i, addr_i, len_i, abort_i, ready_i,
`ifdef ROM_PARITY_EN
        input  parity_o,
`endif
        input  data_o, valid_o, addr_o, last_o, oor_o, busy_o, done_o
    );

    // ROM burst engine side
    modport slave (
        input  start_i, addr_i, len_i, abort_i, ready_i,
`ifdef ROM_PARITY_EN
        output parity_o,
`endif
        output data_o, valid_o, addr_o, last_o, oor_o, busy_o, done_o
    );
endinterface

// File: rtl/rom_burst_reader.sv
// Synchronous ROM with a burst-read engine. One start command (base, length-1)
// streams consecutive words over valid/ready, wrapping at 2**AW, with abort and
// a one-cycle done pulse. Optional macro ROM_PARITY_EN adds a registered even
// parity bit of data_o.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no burst; start_i accepted, abort_i ignored, valid_o low
//   RUN   | burst active; output register refilled while beats remain
module rom_burst_reader #(
    parameter int            W     = 32,
    parameter int            AW    = 8,
    parameter int            DEPTH = 8,
    parameter logic [W-1:0]  FILL  = {W{1'b1}}
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rom_burst_reader_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_addr_q;
    logic [AW-1:0] remain_q;
    logic          pending_q;

    logic [W-1:0]  data_q;
    logic [AW-1:0] addr_q;
    logic          valid_q, last_q, oor_q, done_q;

    logic          accept, load, finish, do_start, do_abort;
    logic          rd_oor;
    logic [W-1:0]  rd_word;

    // Fixed contents; words past the table read zero, unpopulated reads FILL.
    function automatic logic [W-1:0] rom_word(input logic [AW-1:0] a, input logic oor);
        logic [31:0] base;
        case (32'(a))
            32'd0:   base = 32'h0123_4567;
            32'd1:   base = 32'h7654_3210;
            32'd2:   base = 32'hABC2_4681;
            32'd3:   base = 32'hCD12_0201;
            32'd4:   base = 32'hCACA_2357;
            32'd5:   base = 32'hF56A_C87F;
            32'd6:   base = 32'hDED0_5BA7;
            32'd7:   base = 32'h1111_1111;
            default: base = 32'h0000_0000;
        endcase
        return oor ? FILL : W'(base);
    endfunction

    assign rd_oor  = (32'(rd_addr_q) >= DEPTH);
    assign rd_word = rom_word(rd_addr_q, rd_oor);

    // Output/control decode: handshake, refill and termination conditions.
    always_comb begin
        accept   = valid_q & bus.ready_i;
        do_start = (state_q == IDLE) & bus.start_i;
        do_abort = (state_q == RUN) & bus.abort_i;
        load     = (state_q == RUN) & pending_q & (~valid_q | bus.ready_i) & ~bus.abort_i;
        finish   = (state_q == RUN) & accept & last_q & ~bus.abort_i;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (do_start) state_d = RUN;
            RUN:     if (do_abort || finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus read address and remaining-beat down-counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            remain_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (do_start) begin
                rd_addr_q <= bus.addr_i;
                remain_q  <= bus.len_i;
                pending_q <= 1'b1;
            end else if (do_abort) begin
                pending_q <= 1'b0;
            end else if (load) begin
                rd_addr_q <= rd_addr_q + AW'(1);
                if (remain_q == '0) pending_q <= 1'b0;
                else                remain_q  <= remain_q - AW'(1);
            end
        end
    end

    // Output register: refill on load, drop valid on a bare accept or abort.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            oor_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= finish;
            if (do_abort) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else if (load) begin
                data_q  <= rd_word;
                addr_q  <= rd_addr_q;
                valid_q <= 1'b1;
                last_q  <= (remain_q == '0);
                oor_q   <= rd_oor;
            end else if (accept) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

`ifdef ROM_PARITY_EN
    logic parity_q;

    // Parity travels with the data word it describes.
    always_ff @(posedge clk_i) begin
        if (rst_i)     parity_q <= 1'b0;
        else if (load) parity_q <= ^rd_word;
    end

    assign bus.parity_o = parity_q;
`endif

    assign bus.data_o  = data_q;
    assign bus.addr_o  = addr_q;
    assign bus.valid_o = valid_q;
    assign bus.last_o  = last_q;
    assign bus.oor_o   = oor_q;
    assign bus.done_o  = done_q;
    assign bus.busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader (default parameters). Expected
// beats are queued when a burst is commanded and popped by a negedge monitor
// on every handshake; scenario tasks check timing, done/busy and abort/reset.
module tb_rom_burst_reader;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  addr;
        logic        last;
        logic        oor;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    checks = 0;
    int    failures = 0;
    int    beat_cnt = 0;
    int    done_cnt = 0;
    beat_t sb[$];

    rom_burst_reader_if #(.W(32), .AW(8)) bus ();

    rom_burst_reader #(.W(32), .AW(8), .DEPTH(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(input logic [7:0] a);
        case (a)
            8'd0:    return 32'h0123_4567;
            8'd1:    return 32'h7654_3210;
            8'd2:    return 32'hABC2_4681;
            8'd3:    return 32'hCD12_0201;
            8'd4:    return 32'hCACA_2357;
            8'd5:    return 32'hF56A_C87F;
            8'd6:    return 32'hDED0_5BA7;
            8'd7:    return 32'h1111_1111;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic push_burst(input logic [7:0] a, input logic [7:0] len);
        beat_t e;
        for (int i = 0; i <= int'(len); i++) begin
            e.addr = a + 8'(i);
            e.data = exp_word(e.addr);
            e.last = (i == int'(len));
            e.oor  = (e.addr >= 8'd8);
            sb.push_back(e);
        end
    endtask

    // Scoreboard monitor: pops on each handshake, checks hold stability and done.
    task automatic monitor();
        beat_t e;
        beat_t held;
        logic  hold_pending = 1'b0;
        logic  prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pending = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (bus.done_o) begin
                    done_cnt++;
                    checks++;
                    if (bus.busy_o !== 1'b0) begin
                        failures++;
                        $display("FAIL done_busy: busy_o=%b required 0 while done_o=1", bus.busy_o);
                    end
                    checks++;
                    if (prev_done) begin
                        failures++;
                        $display("FAIL done_width: done_o high two cycles in a row, required one");
                    end
                end
                if (hold_pending && bus.valid_o) begin
                    checks++;
                    if ({bus.data_o, bus.addr_o, bus.last_o, bus.oor_o} !== held) begin
                        failures++;
                        $display("FAIL hold: data=%h addr=%h last=%b oor=%b required data=%h addr=%h last=%b oor=%b",
                                 bus.data_o, bus.addr_o, bus.last_o, bus.oor_o,
                                 held.data, held.addr, held.last, held.oor);
                    end
                end
                if (bus.valid_o && bus.ready_i) begin
                    beat_cnt++;
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL extra_beat: data=%h addr=%h with no beat outstanding, required none",
                                 bus.data_o, bus.addr_o);
                    end else begin
                        e = sb.pop_front();
                        if ({bus.data_o, bus.addr_o, bus.last_o, bus.oor_o} !== e) begin
                            failures++;
                            $display("FAIL beat: data=%h addr=%h last=%b oor=%b required data=%h addr=%h last=%b oor=%b",
                                     bus.data_o, bus.addr_o, bus.last_o, bus.oor_o,
                                     e.data, e.addr, e.last, e.oor);
                        end
`ifdef ROM_PARITY_EN
                        checks++;
                        if (bus.parity_o !== ^e.data) begin
                            failures++;
                            $display("FAIL parity: parity_o=%b required %b for data %h",
                                     bus.parity_o, ^e.data, e.data);
                        end
`endif
                    end
                end
                hold_pending = bus.valid_o && !bus.ready_i;
                held = {bus.data_o, bus.addr_o, bus.last_o, bus.oor_o};
                prev_done = bus.done_o;
            end
        end
    endtask

    task automatic drive_idle();
        bus.start_i = 1'b0;
        bus.addr_i  = 8'h00;
        bus.len_i   = 8'h00;
        bus.abort_i = 1'b0;
        bus.ready_i = 1'b1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!bus.done_o && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!bus.done_o) begin
            failures++;
            $display("FAIL %s_timeout: done_o not seen within %0d cycles, required a pulse", name, budget);
        end
    endtask

    task automatic wait_beats(input int target, input int budget, input string name);
        int n = 0;
        while (beat_cnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (beat_cnt < target) begin
            failures++;
            $display("FAIL %s_timeout: beats=%0d required %0d", name, beat_cnt, target);
        end
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_missing: %0d beats outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.data_o, bus.valid_o, bus.addr_o, bus.last_o, bus.oor_o, bus.busy_o, bus.done_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: data=%h valid=%b addr=%h last=%b oor=%b busy=%b done=%b required all 0",
                     bus.data_o, bus.valid_o, bus.addr_o, bus.last_o, bus.oor_o, bus.busy_o, bus.done_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_burst();
        int d0 = done_cnt;
        bus.start_i = 1'b1; bus.addr_i = 8'h00; bus.len_i = 8'd7; bus.ready_i = 1'b1;
        push_burst(8'h00, 8'd7);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL latency_first: valid=%b busy=%b required valid=0 busy=1", bus.valid_o, bus.busy_o);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.addr_o !== 8'h00) begin
            failures++;
            $display("FAIL latency_second: valid=%b addr=%h required valid=1 addr=00", bus.valid_o, bus.addr_o);
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL full_done_time: done=%b busy=%b valid=%b required done=1 busy=0 valid=0",
                     bus.done_o, bus.busy_o, bus.valid_o);
        end
        repeat (3) @(posedge clk);
        #1;
        check_sb_empty("full");
        checks++;
        if (done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL full_done_count: done pulses=%0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_wrap();
        bus.start_i = 1'b1; bus.addr_i = 8'hFE; bus.len_i = 8'd3; bus.ready_i = 1'b1;
        push_burst(8'hFE, 8'd3);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        wait_done(20, "wrap");
        @(posedge clk); #1;
        check_sb_empty("wrap");
    endtask

    task automatic test_backpressure();
        logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int b0 = beat_cnt;
        bus.start_i = 1'b1; bus.addr_i = 8'h02; bus.len_i = 8'd2; bus.ready_i = 1'b0;
        push_burst(8'h02, 8'd2);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            bus.ready_i = pat[i];
        end
        @(posedge clk); #1;
        bus.ready_i = 1'b1;
        wait_done(20, "bp");
        @(posedge clk); #1;
        check_sb_empty("bp");
        checks++;
        if (beat_cnt != b0 + 3) begin
            failures++;
            $display("FAIL bp_count: beats=%0d required 3", beat_cnt - b0);
        end
    endtask

    task automatic test_abort();
        int d0 = done_cnt;
        int b0 = beat_cnt;
        bus.start_i = 1'b1; bus.addr_i = 8'h00; bus.len_i = 8'd7; bus.ready_i = 1'b1;
        push_burst(8'h00, 8'd7);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        wait_beats(b0 + 3, 20, "abort");
        bus.abort_i = 1'b1;
        bus.ready_i = 1'b0;
        @(posedge clk); #1;
        bus.abort_i = 1'b0;
        bus.ready_i = 1'b1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.last_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: valid=%b busy=%b last=%b required all 0",
                     bus.valid_o, bus.busy_o, bus.last_o);
        end
        sb.delete();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0 || beat_cnt != b0 + 3) begin
            failures++;
            $display("FAIL abort_quiet: done pulses=%0d beats=%0d required 0 and 3",
                     done_cnt - d0, beat_cnt - b0);
        end
        bus.start_i = 1'b1; bus.addr_i = 8'h05; bus.len_i = 8'd0;
        push_burst(8'h05, 8'd0);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        wait_done(10, "single");
        @(posedge clk); #1;
        check_sb_empty("single");
    endtask

    task automatic test_reset_mid_and_busy_start();
        int d0 = done_cnt;
        int b0;
        bus.start_i = 1'b1; bus.addr_i = 8'h00; bus.len_i = 8'd7; bus.ready_i = 1'b1;
        push_burst(8'h00, 8'd7);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        wait_beats(beat_cnt + 4, 20, "midrst");
        rst = 1'b1;
        bus.ready_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.data_o, bus.valid_o, bus.addr_o, bus.last_o, bus.oor_o, bus.busy_o, bus.done_o} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: data=%h valid=%b addr=%h last=%b oor=%b busy=%b done=%b required all 0",
                     bus.data_o, bus.valid_o, bus.addr_o, bus.last_o, bus.oor_o, bus.busy_o, bus.done_o);
        end
        rst = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL midrst_done: done pulses=%0d required 0", done_cnt - d0);
        end
        b0 = beat_cnt;
        bus.start_i = 1'b1; bus.addr_i = 8'h00; bus.len_i = 8'd2; bus.ready_i = 1'b0;
        push_burst(8'h00, 8'd2);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL busy_level: busy_o=%b required 1", bus.busy_o);
        end
        bus.start_i = 1'b1; bus.addr_i = 8'h05; bus.len_i = 8'd7;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.ready_i = 1'b1;
        wait_done(20, "busystart");
        repeat (4) @(posedge clk);
        #1;
        check_sb_empty("busystart");
        checks++;
        if (beat_cnt != b0 + 3) begin
            failures++;
            $display("FAIL busystart_count: beats=%0d required 3", beat_cnt - b0);
        end
    endtask

    initial begin
        drive_idle();
        fork
            monitor();
        join_none
        test_reset();
        test_full_burst();
        test_wrap();
        test_backpressure();
        test_abort();
        test_reset_mid_and_busy_start();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
